// File: rtl/nios_sysid_checker.sv
// Purpose: Avalon-MM read master that fetches sysid word 0 (ID) and word 1 (timestamp) and checks both.
// Latency: done rises 4 cycles after REQ_ID entry with a zero-wait slave returning data one cycle after accept.
// Backpressure: address/read held stable while avm_waitrequest=1; each phase is bounded by TIMEOUT_CYCLES.
module nios_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd591751049,
  parameter logic [31:0] EXPECTED_TS    = 32'd1603541705,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_ID = 3'd1,
    RSP_ID = 3'd2,
    REQ_TS = 3'd3,
    RSP_TS = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [16:0] TO_LIMIT = TIMEOUT_CYCLES[16:0];

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        auto_pend_q;
  logic        launch;
  logic        cap_id;
  logic        cap_ts;
  logic        set_to;
  logic        phase_last;

  // The cycle in progress is the last one the current phase is allowed to use.
  assign phase_last = ({1'b0, cnt_q} + 17'd1) >= TO_LIMIT;

  // State register; the auto-start token is re-armed by every reset and consumed on the first idle cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      auto_pend_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= 1'b0;
    end
  end

  // Next-state, capture strobes and bus/status outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    set_to      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state_q)
      IDLE: begin
        if ((AUTO_START && auto_pend_q) || start) begin
          state_d = REQ_ID;
          launch  = 1'b1;
        end
      end
      REQ_ID: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_id  = 1'b1;
          state_d = REQ_TS;
        end else if (phase_last) begin
          set_to  = 1'b1;
          state_d = FIN;
        end else if (!avm_waitrequest) begin
          state_d = RSP_ID;
        end
      end
      RSP_ID: begin
        busy = 1'b1;
        if (avm_readdatavalid) begin
          cap_id  = 1'b1;
          state_d = REQ_TS;
        end else if (phase_last) begin
          set_to  = 1'b1;
          state_d = FIN;
        end
      end
      REQ_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = FIN;
        end else if (phase_last) begin
          set_to  = 1'b1;
          state_d = FIN;
        end else if (!avm_waitrequest) begin
          state_d = RSP_TS;
        end
      end
      RSP_TS: begin
        busy = 1'b1;
        if (avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = FIN;
        end else if (phase_last) begin
          set_to  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          state_d = REQ_ID;
          launch  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-phase cycle counter: restarts when a request phase is entered, runs while a read is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if ((state_d != state_q) && ((state_d == REQ_ID) || (state_d == REQ_TS))) begin
      cnt_q <= 16'd0;
    end else if (busy) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Result registers: cleared when a check launches so a timed-out phase leaves its value/match at 0.
  always_ff @(posedge clock) begin
    if (reset || launch) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
        id_match <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_match <= (avm_readdata == EXPECTED_TS);
      end
      if (set_to) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Directed bench for nios_sysid_checker against a configurable behavioural sysid slave.
// Outputs are driven and sampled on the falling edge; k counts falling edges from REQ_ID entry.
// Slave knobs: stall length, response enable, same-cycle response, returned data words.
module tb_nios_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'd591751049;
  localparam logic [31:0] GOOD_TS = 32'd1603541705;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int errors = 0;
  int checks = 0;

  // slave model configuration
  logic [31:0] id_data    = GOOD_ID;
  logic [31:0] ts_data    = GOOD_TS;
  int          stall_cfg  = 0;
  bit          respond_en = 1'b1;
  bit          same_cycle = 1'b0;

  int          stall_cnt   = 0;
  int          ts_req_cnt  = 0;
  logic        rdv_q       = 1'b0;
  logic [31:0] rdata_q     = 32'd0;
  logic        accept;

  always #5 clock = ~clock;

  nios_sysid_checker #(
    .EXPECTED_ID   (GOOD_ID),
    .EXPECTED_TS   (GOOD_TS),
    .TIMEOUT_CYCLES(8),
    .AUTO_START    (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_match         (id_match),
    .ts_match         (ts_match),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  assign avm_waitrequest   = avm_read && (stall_cnt < stall_cfg);
  assign accept            = avm_read && !avm_waitrequest;
  assign avm_readdatavalid = same_cycle ? (accept && respond_en) : rdv_q;
  assign avm_readdata      = same_cycle ? (avm_address ? ts_data : id_data) : rdata_q;

  // behavioural slave: stalls stall_cfg cycles per request, answers one cycle after accept
  always @(posedge clock) begin
    if (reset) begin
      stall_cnt <= 0;
      rdv_q     <= 1'b0;
    end else begin
      if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else if (accept)                 stall_cnt <= 0;
      rdv_q   <= accept && respond_en && !same_cycle;
      rdata_q <= avm_address ? ts_data : id_data;
      if (avm_read && avm_address) ts_req_cnt <= ts_req_cnt + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, avm_read, avm_address} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: busy/done/read/addr=%b want 0000", {busy, done, avm_read, avm_address});
    end
    checks++;
    if ({id_match, ts_match, timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {id_match, ts_match, timeout});
    end
    checks++;
    if ({id_value, ts_value} !== 64'd0) begin
      errors++; $display("FAIL reset_values: id=%h ts=%h want 0", id_value, ts_value);
    end
  endtask

  task automatic test_auto_pass();
    int cyc;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, avm_read, avm_address} !== 3'b110) begin
      errors++; $display("FAIL auto_launch: busy/read/addr=%b want 110", {busy, avm_read, avm_address});
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL auto_latency: got %0d want 4", cyc); end
    checks++;
    if ({id_match, ts_match, timeout} !== 3'b110) begin
      errors++; $display("FAIL auto_flags: got %b want 110", {id_match, ts_match, timeout});
    end
    checks++;
    if (id_value !== GOOD_ID || ts_value !== GOOD_TS) begin
      errors++; $display("FAIL auto_values: id=%0d ts=%0d want %0d %0d", id_value, ts_value, GOOD_ID, GOOD_TS);
    end
  endtask

  task automatic test_id_zero();
    int cyc;
    id_data = 32'd0;
    pulse_start();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL idzero_done_clear: got %b want 0", done); end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL idzero_latency: got %0d want 4", cyc); end
    checks++;
    if ({id_match, ts_match, timeout} !== 3'b010) begin
      errors++; $display("FAIL idzero_flags: got %b want 010", {id_match, ts_match, timeout});
    end
    checks++;
    if (id_value !== 32'd0) begin errors++; $display("FAIL idzero_value: got %h want 0", id_value); end
    id_data = GOOD_ID;
  endtask

  task automatic test_stall();
    bit exp_read;
    bit exp_addr;
    stall_cfg = 5;
    pulse_start();
    for (int k = 0; k < 14; k++) begin
      exp_read = (k <= 5) || (k >= 7 && k <= 12);
      exp_addr = (k >= 7);
      checks++;
      if (avm_read !== exp_read || (exp_read && avm_address !== exp_addr) || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_k%0d: read=%b addr=%b done=%b want read=%b addr=%b done=0",
                 k, avm_read, avm_address, done, exp_read, exp_addr);
      end
      @(negedge clock);
    end
    checks++;
    if ({done, id_match, ts_match, timeout} !== 4'b1110) begin
      errors++; $display("FAIL stall_end: done/id/ts/to=%b want 1110", {done, id_match, ts_match, timeout});
    end
    stall_cfg = 0;
  endtask

  task automatic test_timeout();
    int ts_before;
    respond_en = 1'b0;
    ts_before  = ts_req_cnt;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (done !== 1'b0 || avm_address !== 1'b0) begin
        errors++; $display("FAIL to_k%0d: done=%b addr=%b want 0 0", k, done, avm_address);
      end
      @(negedge clock);
    end
    checks++;
    if ({done, timeout, avm_read, busy} !== 4'b1100) begin
      errors++; $display("FAIL to_end: done/to/read/busy=%b want 1100", {done, timeout, avm_read, busy});
    end
    checks++;
    if ({id_match, ts_match} !== 2'b00 || id_value !== 32'd0) begin
      errors++; $display("FAIL to_capture: id/ts match=%b id=%h want 00 0", {id_match, ts_match}, id_value);
    end
    checks++;
    if (ts_req_cnt !== ts_before) begin
      errors++; $display("FAIL to_no_ts_phase: ts requests=%0d want %0d", ts_req_cnt, ts_before);
    end
    respond_en = 1'b1;
  endtask

  task automatic test_same_cycle();
    int cyc;
    same_cycle = 1'b1;
    pulse_start();
    wait_done(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL same_latency: got %0d want 2", cyc); end
    checks++;
    if ({id_match, ts_match, timeout} !== 3'b110) begin
      errors++; $display("FAIL same_flags: got %b want 110", {id_match, ts_match, timeout});
    end
    same_cycle = 1'b0;
  endtask

  task automatic test_start_ignored();
    int cyc;
    pulse_start();
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, avm_read} !== 2'b10) begin
      errors++; $display("FAIL ign_rsp_ts: busy/read=%b want 10", {busy, avm_read});
    end
    pulse_start();
    checks++;
    if ({done, busy, id_match, ts_match} !== 4'b1011) begin
      errors++; $display("FAIL ign_done: done/busy/id/ts=%b want 1011", {done, busy, id_match, ts_match});
    end
    repeat (3) @(negedge clock);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL ign_sticky: done/busy=%b want 10", {done, busy});
    end
    pulse_start();
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++; $display("FAIL restart_clear: done/busy=%b want 01", {done, busy});
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || {id_match, ts_match} !== 2'b11) begin
      errors++; $display("FAIL restart_done: cyc=%0d match=%b want 4 11", cyc, {id_match, ts_match});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_start();
    @(negedge clock);
    checks++;
    if ({busy, avm_read} !== 2'b10) begin
      errors++; $display("FAIL rmid_rsp_id: busy/read=%b want 10", {busy, avm_read});
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, avm_read, avm_address, id_match, ts_match, timeout} !== 7'd0 ||
        {id_value, ts_value} !== 64'd0) begin
      errors++; $display("FAIL rmid_cleared: ctrl=%b id=%h ts=%h want all 0",
                         {busy, done, avm_read, avm_address, id_match, ts_match, timeout}, id_value, ts_value);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, avm_read, avm_address} !== 3'b110) begin
      errors++; $display("FAIL rmid_rerun: busy/read/addr=%b want 110", {busy, avm_read, avm_address});
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || {id_match, ts_match, timeout} !== 3'b110) begin
      errors++; $display("FAIL rmid_pass: cyc=%0d flags=%b want 4 110", cyc, {id_match, ts_match, timeout});
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_auto_pass();
    test_id_zero();
    test_stall();
    test_timeout();
    test_same_cycle();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
